// File: rtl/rf_pkg.sv
// Shared constants and helpers for the multiport register file.
package rf_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  // Address of the hardwired zero register when ZERO_REG is enabled.
  localparam int unsigned REG_ZERO = 0;

  // Widest busy vector popcount accepts (ADDR_W up to 10).
  localparam int unsigned POP_MAX = 1024;

  function automatic int unsigned popcount(input logic [POP_MAX-1:0] vec);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < POP_MAX; i++) begin
      cnt += 32'(vec[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: zero register, write bypass and scoreboard ready.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic              wr0_en_i,
  input  logic [ADDR_W-1:0] wr0_addr_i,
  input  logic [DATA_W-1:0] wr0_data_i,
  input  logic              wr1_en_i,
  input  logic [ADDR_W-1:0] wr1_addr_i,
  input  logic [DATA_W-1:0] wr1_data_i,
  input  logic [DATA_W-1:0] reg_data_i,
  input  logic              reg_busy_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_ready_o
);

  // Priority mux: reset, zero register, write port 1, write port 0, storage.
  always_comb begin
    rd_data_o  = reg_data_i;
    rd_ready_o = !reg_busy_i;
    if (rst_i) begin
      rd_data_o  = '0;
      rd_ready_o = 1'b1;
    end else if (ZERO_REG != 0 && rd_addr_i == ADDR_W'(REG_ZERO)) begin
      rd_data_o  = '0;
      rd_ready_o = 1'b1;
    end else if (wr1_en_i && wr1_addr_i == rd_addr_i) begin
      rd_data_o  = wr1_data_i;
      rd_ready_o = 1'b1;
    end else if (wr0_en_i && wr0_addr_i == rd_addr_i) begin
      rd_data_o  = wr0_data_i;
      rd_ready_o = 1'b1;
    end
  end

endmodule

// File: rtl/rf_multiport.sv
// Parametrised register file: NUM_RD read ports, two write ports, busy scoreboard.
module rf_multiport
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_ready,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic                     flush,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;
  logic              wr0_ok, wr1_ok;
  logic              rsv_ok;
  logic [POP_MAX-1:0] busy_ext;

  assign wr0_ok = wr0_en && !(ZERO_REG != 0 && wr0_addr == ADDR_W'(REG_ZERO));
  assign wr1_ok = wr1_en && !(ZERO_REG != 0 && wr1_addr == ADDR_W'(REG_ZERO));
  assign rsv_ok = rsv_en && !(ZERO_REG != 0 && rsv_addr == ADDR_W'(REG_ZERO));

  // Storage: write port 1 is applied last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      if (wr0_ok) regs_q[wr0_addr] <= wr0_data;
      if (wr1_ok) regs_q[wr1_addr] <= wr1_data;
    end
  end

  // Scoreboard next state: reserve beats flush, flush beats write-clear.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned r = 0; r < DEPTH; r++) begin
      if (rsv_ok && rsv_addr == ADDR_W'(r)) begin
        busy_d[r] = 1'b1;
      end else if (flush) begin
        busy_d[r] = 1'b0;
      end else if ((wr0_en && wr0_addr == ADDR_W'(r)) ||
                   (wr1_en && wr1_addr == ADDR_W'(r))) begin
        busy_d[r] = 1'b0;
      end
    end
  end

  // Busy count is recomputed from the next busy vector every cycle.
  always_comb begin
    busy_ext              = '0;
    busy_ext[DEPTH-1:0]   = busy_d;
    busy_cnt_d            = (ADDR_W+1)'(popcount(busy_ext));
  end

  // Scoreboard and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    assign addr = rd_addr[i*ADDR_W +: ADDR_W];

    rf_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_rd (
      .rst_i      (rst),
      .rd_addr_i  (addr),
      .wr0_en_i   (wr0_en),
      .wr0_addr_i (wr0_addr),
      .wr0_data_i (wr0_data),
      .wr1_en_i   (wr1_en),
      .wr1_addr_i (wr1_addr),
      .wr1_data_i (wr1_data),
      .reg_data_i (regs_q[addr]),
      .reg_busy_i (busy_q[addr]),
      .rd_data_o  (rd_data[i*DATA_W +: DATA_W]),
      .rd_ready_o (rd_ready[i])
    );
  end

endmodule

// File: doc/rf_multiport.md
Name: rf_multiport

Overview:
- Parametrised general-purpose register file for the MIPS core; next generation of the single-write, two-read register file.
- Adds configurable width, depth and read-port count, plus a second write port (ALU result and load/writeback).
- Adds synchronous clear and same-cycle write-to-read bypass.
- Adds a per-register busy scoreboard so decode can stall on pending long-latency writes.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports, 1..4
- ZERO_REG, 1, if 1, register 0 is hardwired to zero and is never busy

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- rd_addr  input  NUM_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W]
- rd_data  output  NUM_RD*DATA_W  read data; port i occupies bits [i*DATA_W +: DATA_W]
- rd_ready  output  NUM_RD  1 = addressed register not busy (bypassed value counts as ready)
- wr0_en  input  1  write port 0 enable (ALU writeback)
- wr0_addr  input  ADDR_W  write port 0 address
- wr0_data  input  DATA_W  write port 0 data
- wr1_en  input  1  write port 1 enable (load writeback)
- wr1_addr  input  ADDR_W  write port 1 address
- wr1_data  input  DATA_W  write port 1 data
- rsv_en  input  1  reserve: mark rsv_addr busy (load issued)
- rsv_addr  input  ADDR_W  register to reserve
- flush  input  1  clear all busy bits; register contents unchanged
- busy_cnt  output  ADDR_W+1  number of registers currently busy

Behaviour:
- Reset: rst sampled high at a rising edge clears every register to 0, clears every busy bit and sets busy_cnt to 0.
- During reset, reads return 0 and rd_ready is all ones.
- rst has priority over writes, reserves and flush in the same cycle.
- Reads are combinational with zero latency. For each port i, the first matching case below applies:
  - ZERO_REG=1 and rd_addr==0: data 0, ready 1.
  - wr1_en and wr1_addr==rd_addr (write port 1 has priority): data wr1_data, ready 1.
  - wr0_en and wr0_addr==rd_addr: data wr0_data, ready 1.
  - Otherwise: data regFile[rd_addr], ready = !busy[rd_addr].
- Writes take effect at the rising edge.
  - wr0 and wr1 to the same address in the same cycle: wr1_data is stored.
  - With ZERO_REG=1, writes to address 0 are discarded.
- Busy scoreboard, next state per register r:
  - rst: 0.
  - Else rsv_en and rsv_addr==r (and r!=0 when ZERO_REG=1): 1. A reserve wins over a simultaneous write or flush, because it represents a newer producer.
  - Else flush: 0.
  - Else a write to r on either port: 0.
  - Else: hold.
- Reserving a register that is already busy keeps it busy; this is not an error.
- A write to a non-busy register is a normal write; the busy bit stays 0.
- busy_cnt is registered and always equals the population count of the busy bits after each edge.
  - It must be updated from the computed next busy vector, not tracked as an incremental counter.
  - Maximum value is 2**ADDR_W, or 2**ADDR_W-1 when ZERO_REG=1.
- Address decoding wraps by truncation only; all addresses in range 0..2**ADDR_W-1 are valid.
- No X-propagation on disabled write ports: their address and data are ignored.

Decomposition:
- Package rf_pkg holds:
  - default DATA_W and ADDR_W constants
  - the REG_ZERO address constant
  - a function popcount(vec) used for busy_cnt
- One natural sub-module: rf_read_port, instantiated NUM_RD times with a generate loop.
  - It performs the zero, bypass and priority mux and produces rd_ready for one port.
- Storage, write logic and scoreboard stay in the top module.

Test Plan:
- Reset, then write wr0 addr 3 data 0x1234_5678; next cycle read port 0 addr 3 -> 0x12345678, ready 1; read addr 0 -> 0.
- Same-cycle bypass: wr0 addr 7 data 0xA5A5A5A5, with port 1 reading addr 7 in that cycle -> rd_data 0xA5A5A5A5 the same cycle, ready 1.
- Dual-write conflict: wr0 and wr1 both to addr 9 with 0x11 and 0x22 -> next-cycle read returns 0x22.
- Scoreboard sequence:
  - rsv addr 5 -> next cycle rd_ready=0 for addr 5, busy_cnt 1.
  - wr1 addr 5 data 0x99 -> same-cycle ready 1 and data 0x99; afterwards busy_cnt 0.
- Reserve/write/flush collision: reserve addrs 4, 6, 8 -> busy_cnt 3.
  - Then in one cycle: flush, rsv addr 6, and wr0 addr 6 data 0x55 -> busy_cnt 1, addr 6 busy, stored data 0x55.
- Zero register and reset mid-operation:
  - rsv addr 0 and wr0 addr 0 data 0xFF -> addr 0 reads 0 and ready, busy_cnt unchanged.
  - Then assert rst together with wr0 addr 2 data 0x77 -> addr 2 reads 0 afterwards, all ready, busy_cnt 0.
